// File: rtl/weight_sign_buffer_read_ctrl.sv
// Loads one layer of 64-bit weight-sign words into 32 row RAMs and replays the buffer with all rows side by side.
// Read latency 1 clk; tready follows en_to_fifo in LOAD only; value_en=0 stalls replay (valid drops, dout holds).
module weight_sign_buffer_read_ctrl #(
  parameter int Ifm_Width                    = 9,
  parameter int weight_sign_Ram_Row          = 32,
  parameter int weight_sign_Axi_Width        = 64,
  parameter int weight_sign_Write_Data_Width = 64,
  parameter int weight_sign_Read_Data_Width  = 64,
  parameter int weight_sign_Write_Addr_Width = 11,
  parameter int weight_sign_Read_Addr_Width  = 11
) (
  input  logic                                                      clk,
  input  logic                                                      rst,
  input  logic                                                      value_en,
  input  logic                                                      weight_sign_Sys_start,
  input  logic [Ifm_Width-1:0]                                      Addrtimes_end,
  input  logic [weight_sign_Read_Addr_Width+4:0]                    k_k_channels,
  output logic [weight_sign_Read_Data_Width-1:0]                    valid,
  input  logic [weight_sign_Axi_Width-1:0]                          weight_sign_s_axis_tdata,
  input  logic                                                      weight_sign_s_axis_tvalid,
  output logic                                                      weight_sign_s_axis_tready,
  input  logic                                                      en_to_fifo,
  output logic [weight_sign_Read_Data_Width*weight_sign_Ram_Row-1:0] dout
);

  localparam int AW    = weight_sign_Read_Addr_Width;
  localparam int KW    = AW + 5;
  localparam int RB    = $clog2(weight_sign_Ram_Row);
  localparam int RW    = weight_sign_Read_Data_Width;
  localparam int ROWS  = weight_sign_Ram_Row;
  localparam int DEPTH = 2 ** weight_sign_Write_Addr_Width;

  typedef enum logic [1:0] {IDLE, LOAD, READ} state_t;

  state_t                                  state, state_nxt;
  logic [Ifm_Width-1:0]                    times_q;
  logic [KW-1:0]                           k_q;
  logic [KW-1:0]                           beat_cnt;
  logic [AW-1:0]                           rd_addr;
  logic [Ifm_Width-1:0]                    pass_cnt;
  logic [AW:0]                             addr_end;
  logic                                    beat_acc, last_beat, issue, last_addr, last_pass;
  logic [weight_sign_Write_Data_Width-1:0] ram [ROWS][DEPTH];

  assign addr_end  = {1'b0, k_q[KW-1:RB]} + {{AW{1'b0}}, |k_q[RB-1:0]};
  assign beat_acc  = weight_sign_s_axis_tvalid & weight_sign_s_axis_tready;
  assign last_beat = beat_acc & (beat_cnt == k_q - 1'b1);
  assign issue     = (state == READ) & value_en;
  assign last_addr = ({1'b0, rd_addr} == addr_end - 1'b1);
  assign last_pass = (pass_cnt == times_q - 1'b1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt                 = state;
    weight_sign_s_axis_tready = 1'b0;
    case (state)
      IDLE: begin
        // A zero repeat count or zero-length layer never leaves IDLE.
        if (weight_sign_Sys_start && (Addrtimes_end != '0) && (k_k_channels != '0))
          state_nxt = LOAD;
      end
      LOAD: begin
        weight_sign_s_axis_tready = en_to_fifo;
        if (last_beat) state_nxt = READ;
      end
      READ: begin
        if (issue && last_addr && last_pass) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      times_q  <= '0;
      k_q      <= '0;
      beat_cnt <= '0;
      rd_addr  <= '0;
      pass_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (weight_sign_Sys_start) begin
            times_q  <= Addrtimes_end;
            k_q      <= k_k_channels;
            beat_cnt <= '0;
            rd_addr  <= '0;
            pass_cnt <= '0;
          end
        end
        LOAD: begin
          if (beat_acc) beat_cnt <= beat_cnt + 1'b1;
        end
        READ: begin
          if (issue) begin
            if (last_addr) begin
              rd_addr  <= '0;
              pass_cnt <= pass_cnt + 1'b1;
            end else begin
              rd_addr  <= rd_addr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Beat n lands in row n%32 at address n>>5.
  always_ff @(posedge clk) begin
    if (rst && beat_acc)
      ram[beat_cnt[RB-1:0]][beat_cnt[KW-1:RB]] <= weight_sign_s_axis_tdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= '0;
      dout  <= '0;
    end else begin
      valid <= '0;
      if (issue) begin
        for (int r = 0; r < ROWS; r++) begin
          if ({rd_addr, RB'(r)} < k_q) begin
            valid[r]          <= 1'b1;
            dout[r*RW +: RW]  <= ram[r][rd_addr];
          end else begin
            dout[r*RW +: RW]  <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_weight_sign_buffer_read_ctrl.sv
// Directed bench for weight_sign_buffer_read_ctrl with a behavioural upstream FIFO of numbered words.
module tb_weight_sign_buffer_read_ctrl;

  logic          clk = 1'b0;
  logic          rst;
  logic          value_en;
  logic          sys_start;
  logic [8:0]    Addrtimes_end;
  logic [15:0]   k_k_channels;
  logic [63:0]   valid;
  logic [63:0]   tdata;
  logic          tvalid;
  logic          tready;
  logic          en_to_fifo;
  logic [2047:0] dout;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_ptr   = 0;
  int fifo_end = 0;
  int l2_base  = 0;

  localparam logic [63:0] ALL32 = 64'h0000_0000_FFFF_FFFF;

  function automatic logic [63:0] word(input int n);
    return {~32'(n), 32'(n) * 32'd3 + 32'h1000};
  endfunction

  always #5 clk = ~clk;

  assign tvalid = (rd_ptr < fifo_end);
  assign tdata  = word(rd_ptr);

  always @(posedge clk) begin
    if (tvalid && tready) rd_ptr <= rd_ptr + 1;
  end

  weight_sign_buffer_read_ctrl dut (
    .clk                       (clk),
    .rst                       (rst),
    .value_en                  (value_en),
    .weight_sign_Sys_start     (sys_start),
    .Addrtimes_end             (Addrtimes_end),
    .k_k_channels              (k_k_channels),
    .valid                     (valid),
    .weight_sign_s_axis_tdata  (tdata),
    .weight_sign_s_axis_tvalid (tvalid),
    .weight_sign_s_axis_tready (tready),
    .en_to_fifo                (en_to_fifo),
    .dout                      (dout)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_layer(input int k, input int times, input int avail,
                            output int base, output int taken, output bit ok);
    bit seen = 0;
    ok = 0;
    @(negedge clk);
    base          = rd_ptr;
    fifo_end      = rd_ptr + avail;
    k_k_channels  = 16'(k);
    Addrtimes_end = 9'(times);
    sys_start     = 1'b1;
    @(negedge clk);
    sys_start     = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (tready) seen = 1;
      else if (seen) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    taken = rd_ptr - base;
  endtask

  task automatic test_reset();
    bit bad = 0;
    rst = 1'b0; value_en = 1'b0; sys_start = 1'b0; en_to_fifo = 1'b1;
    Addrtimes_end = '0; k_k_channels = '0;
    repeat (10) @(negedge clk);
    n_checks++; if (tready !== 1'b0) $display("FAIL reset_tready: got %b want 0", tready);
    if (tready !== 1'b0) n_fail++;
    n_checks++; if (valid !== 64'h0) begin n_fail++; $display("FAIL reset_valid: got %h want 0", valid); end
    n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL reset_dout: got nonzero want 0"); end
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (tready !== 1'b0) bad = 1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL idle_tready: got 1 want 0"); end
  endtask

  task automatic test_load();
    int base, taken; bit ok;
    load_layer(1152, 16, 1200, base, taken, ok);
    l2_base = base;
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL load_done: got %b want 1", ok); end
    n_checks++; if (taken !== 1152) begin n_fail++; $display("FAIL load_beats: got %0d want 1152", taken); end
    repeat (5) @(negedge clk);
    n_checks++; if (tready !== 1'b0) begin n_fail++; $display("FAIL load_tready_low: got %b want 0", tready); end
    n_checks++; if (rd_ptr - base !== 1152) begin n_fail++; $display("FAIL load_excess_kept: got %0d want 1152", rd_ptr - base); end
    n_checks++; if (valid !== 64'h0) begin n_fail++; $display("FAIL load_valid_stalled: got %h want 0", valid); end
  endtask

  task automatic test_replay_full();
    int a;
    logic [63:0] exp;
    @(negedge clk);
    value_en = 1'b1;
    for (int i = 0; i < 576; i++) begin
      @(negedge clk);
      a = i % 36;
      n_checks++;
      if (valid !== ALL32) begin n_fail++; $display("FAIL full_valid cyc %0d: got %h want %h", i, valid, ALL32); end
      for (int r = 0; r < 32; r++) begin
        exp = word(l2_base + a * 32 + r);
        n_checks++;
        if (dout[r*64 +: 64] !== exp) begin
          n_fail++; $display("FAIL full_lane cyc %0d lane %0d: got %h want %h", i, r, dout[r*64 +: 64], exp);
        end
      end
    end
    @(negedge clk);
    value_en = 1'b0;
    n_checks++; if (valid !== 64'h0) begin n_fail++; $display("FAIL full_end_valid: got %h want 0", valid); end
    n_checks++; if (dout[63:0] !== word(l2_base + 35 * 32)) begin
      n_fail++; $display("FAIL full_end_hold: got %h want %h", dout[63:0], word(l2_base + 35 * 32));
    end
  endtask

  task automatic test_partial();
    int base, taken, a; bit ok;
    logic [63:0] exp, expv;
    load_layer(40, 2, 40, base, taken, ok);
    n_checks++; if (base !== l2_base + 1152) begin n_fail++; $display("FAIL partial_base: got %0d want %0d", base, l2_base + 1152); end
    n_checks++; if (taken !== 40) begin n_fail++; $display("FAIL partial_beats: got %0d want 40", taken); end
    value_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = i % 2;
      expv = (a == 0) ? ALL32 : 64'h0000_0000_0000_00FF;
      n_checks++;
      if (valid !== expv) begin n_fail++; $display("FAIL partial_valid cyc %0d: got %h want %h", i, valid, expv); end
      for (int r = 0; r < 32; r++) begin
        exp = (a * 32 + r < 40) ? word(base + a * 32 + r) : 64'h0;
        n_checks++;
        if (dout[r*64 +: 64] !== exp) begin
          n_fail++; $display("FAIL partial_lane cyc %0d lane %0d: got %h want %h", i, r, dout[r*64 +: 64], exp);
        end
      end
    end
    @(negedge clk);
    value_en = 1'b0;
    n_checks++; if (valid !== 64'h0) begin n_fail++; $display("FAIL partial_end_valid: got %h want 0", valid); end
  endtask

  task automatic test_stall();
    int base, taken, issued; bit ok, prev;
    logic [63:0] expv;
    logic [63:0] exp_l [32];
    load_layer(64, 2, 64, base, taken, ok);
    n_checks++; if (taken !== 64) begin n_fail++; $display("FAIL stall_beats: got %0d want 64", taken); end
    prev = 0; issued = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      expv = 64'h0;
      if (prev && issued < 4) begin
        expv = ALL32;
        for (int r = 0; r < 32; r++) exp_l[r] = word(base + (issued % 2) * 32 + r);
        issued++;
      end
      n_checks++;
      if (valid !== expv) begin n_fail++; $display("FAIL stall_valid step %0d: got %h want %h", i, valid, expv); end
      if (issued > 0) begin
        for (int r = 0; r < 32; r++) begin
          n_checks++;
          if (dout[r*64 +: 64] !== exp_l[r]) begin
            n_fail++; $display("FAIL stall_lane step %0d lane %0d: got %h want %h", i, r, dout[r*64 +: 64], exp_l[r]);
          end
        end
      end
      value_en = (i % 3 != 1);
      prev = value_en;
    end
    value_en = 1'b0;
  endtask

  task automatic test_abort_and_ignore();
    int base, taken, vcount; bit ok, bad;
    // reset in the middle of LOAD: FIFO runs dry so the load cannot finish
    @(negedge clk);
    fifo_end = rd_ptr + 10; k_k_channels = 16'd100; Addrtimes_end = 9'd1; sys_start = 1'b1;
    @(negedge clk);
    sys_start = 1'b0;
    repeat (15) @(negedge clk);
    n_checks++; if (tready !== 1'b1) begin n_fail++; $display("FAIL midload_tready: got %b want 1", tready); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (tready !== 1'b0) begin n_fail++; $display("FAIL midload_rst_tready: got %b want 0", tready); end
    n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL midload_rst_dout: got nonzero want 0"); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (tready !== 1'b0) begin n_fail++; $display("FAIL midload_idle: got %b want 0", tready); end

    // clean restart after the aborted load
    load_layer(32, 1, 32, base, taken, ok);
    n_checks++; if (taken !== 32) begin n_fail++; $display("FAIL restart_beats: got %0d want 32", taken); end
    value_en = 1'b1;
    @(negedge clk);
    value_en = 1'b0;
    n_checks++; if (valid !== ALL32) begin n_fail++; $display("FAIL restart_valid: got %h want %h", valid, ALL32); end
    n_checks++; if (dout[31*64 +: 64] !== word(base + 31)) begin
      n_fail++; $display("FAIL restart_lane31: got %h want %h", dout[31*64 +: 64], word(base + 31));
    end

    // Sys_start during READ is ignored: exactly 3 output cycles, no new load
    load_layer(32, 3, 64, base, taken, ok);
    value_en = 1'b1;
    vcount = 0; bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid[31:0] !== 32'h0) vcount++;
      if (tready !== 1'b0) bad = 1;
      sys_start = (i == 0);
      k_k_channels = 16'd64; Addrtimes_end = 9'd7;
    end
    sys_start = 1'b0; value_en = 1'b0;
    n_checks++; if (vcount !== 3) begin n_fail++; $display("FAIL ignore_start_count: got %0d want 3", vcount); end
    n_checks++; if (bad) begin n_fail++; $display("FAIL ignore_start_tready: got 1 want 0"); end

    // reset in the middle of READ
    load_layer(32, 5, 32, base, taken, ok);
    value_en = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (valid !== ALL32) begin n_fail++; $display("FAIL midread_valid: got %h want %h", valid, ALL32); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (valid !== 64'h0) begin n_fail++; $display("FAIL midread_rst_valid: got %h want 0", valid); end
    n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL midread_rst_dout: got nonzero want 0"); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (valid !== 64'h0) begin n_fail++; $display("FAIL midread_idle_valid: got %h want 0", valid); end
    value_en = 1'b0;

    // zero-length layer and zero repeat count never leave IDLE
    fifo_end = rd_ptr + 8;
    k_k_channels = 16'd0; Addrtimes_end = 9'd5; sys_start = 1'b1;
    @(negedge clk);
    sys_start = 1'b0; value_en = 1'b1; bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (tready !== 1'b0 || valid !== 64'h0) bad = 1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL k0_start: got activity want none"); end
    k_k_channels = 16'd32; Addrtimes_end = 9'd0; sys_start = 1'b1;
    @(negedge clk);
    sys_start = 1'b0; bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (tready !== 1'b0 || valid !== 64'h0) bad = 1;
    end
    value_en = 1'b0;
    n_checks++; if (bad) begin n_fail++; $display("FAIL times0_start: got activity want none"); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_replay_full();
    test_partial();
    test_stall();
    test_abort_and_ignore();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
